// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
//   Bundles the two requester channels (calculator controller = 0, host loader = 1) and the
//   SRAM-side signals of the memory port arbiter.
//   slave  : arbiter view (requests/addresses/wdata/sram_rdata in; grants, read returns and
//            SRAM controls out).
//   master : requester + SRAM view (the mirror image).
//   Parameters: AW = SRAM address width, DW = SRAM word width.
interface mem_port_arbiter_if #(
    parameter int unsigned AW = 10,
    parameter int unsigned DW = 64
);
    // Requester 0 write/read channels
    logic          wreq_0, wlock_0, wgnt_0;
    logic [AW-1:0] waddr_0;
    logic [DW-1:0] wdata_0;
    logic          rreq_0, rlock_0, rgnt_0, rvalid_0;
    logic [AW-1:0] raddr_0;
    logic [DW-1:0] rdata_0;
    // Requester 1 write/read channels
    logic          wreq_1, wlock_1, wgnt_1;
    logic [AW-1:0] waddr_1;
    logic [DW-1:0] wdata_1;
    logic          rreq_1, rlock_1, rgnt_1, rvalid_1;
    logic [AW-1:0] raddr_1;
    logic [DW-1:0] rdata_1;
    // SRAM side
    logic          sram_we, sram_re;
    logic [AW-1:0] sram_waddr, sram_raddr;
    logic [DW-1:0] sram_wdata, sram_rdata;

    modport slave (
        input  wreq_0, wlock_0, waddr_0, wdata_0, rreq_0, rlock_0, raddr_0,
        input  wreq_1, wlock_1, waddr_1, wdata_1, rreq_1, rlock_1, raddr_1,
        input  sram_rdata,
        output wgnt_0, rgnt_0, rvalid_0, rdata_0,
        output wgnt_1, rgnt_1, rvalid_1, rdata_1,
        output sram_we, sram_waddr, sram_wdata, sram_re, sram_raddr
    );

    modport master (
        output wreq_0, wlock_0, waddr_0, wdata_0, rreq_0, rlock_0, raddr_0,
        output wreq_1, wlock_1, waddr_1, wdata_1, rreq_1, rlock_1, raddr_1,
        output sram_rdata,
        input  wgnt_0, rgnt_0, rvalid_0, rdata_0,
        input  wgnt_1, rgnt_1, rvalid_1, rdata_1,
        input  sram_we, sram_waddr, sram_wdata, sram_re, sram_raddr
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Two-requester arbiter in front of a simple dual-port SRAM (one write port, one read port).
//   Each port has its own round-robin pointer; grants are combinational, the granted
//   requester's address/data drive the SRAM in the grant cycle, and a registered owner bit
//   routes the read data (valid one cycle after sram_re) back to the requester that issued it.
//   Ports:
//     clk_i : clock, rising edge
//     rst_i : synchronous active-high reset; forces all grants/valids/SRAM controls to 0
//     bus   : mem_port_arbiter_if.slave (requester channels + SRAM side)
//   Parameters: AW (address width), DW (word width), LOCK_MAX (max consecutive locked grants).
//   Defaults mirror calculator_pkg::ADDR_W and calculator_pkg::MEM_WORD_SIZE.
//   Optional feature: define MEMARB_LOCK_EN to honour wlock_k/rlock_k. Without it the lock
//   inputs are ignored and no lock state exists.
module mem_port_arbiter #(
    parameter int unsigned AW       = 10,
    parameter int unsigned DW       = 64,
    parameter int unsigned LOCK_MAX = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    mem_port_arbiter_if.slave bus
);
    // Index 0 = write port, 1 = read port; bit k = requester k.
    logic [1:0] port_req  [2];
    logic [1:0] port_lock [2];
    logic [1:0] port_gnt  [2];

    assign port_req[0]  = {bus.wreq_1, bus.wreq_0};
    assign port_req[1]  = {bus.rreq_1, bus.rreq_0};
    assign port_lock[0] = {bus.wlock_1, bus.wlock_0};
    assign port_lock[1] = {bus.rlock_1, bus.rlock_0};

`ifndef MEMARB_LOCK_EN
    logic unused_lock;
    assign unused_lock = ^{port_lock[0], port_lock[1], 32'(LOCK_MAX)};
`endif

    for (genvar p = 0; p < 2; p++) begin : g_port
        logic       prio_q, prio_d;  // requester that wins a tie
        logic [1:0] gnt;
`ifdef MEMARB_LOCK_EN
        localparam int unsigned CntW = $clog2(LOCK_MAX + 1);
        logic            lock_act_q, lock_act_d;
        logic            lock_own_q, lock_own_d;
        logic [CntW-1:0] lock_cnt_q, lock_cnt_d;
        logic [CntW-1:0] cnt_next;
        logic            owner_holds;
`endif

        always_comb begin
            if (port_req[p] == 2'b11) begin
                gnt = prio_q ? 2'b10 : 2'b01;
            end else begin
                gnt = port_req[p];
            end
`ifdef MEMARB_LOCK_EN
            owner_holds = lock_act_q && port_req[p][lock_own_q] && port_lock[p][lock_own_q];
            if (owner_holds) begin
                gnt = lock_own_q ? 2'b10 : 2'b01;
            end
`endif
            if (rst_i) begin
                gnt = 2'b00;
            end

            // Pointer moves only on a grant, away from the requester just served.
            prio_d = prio_q;
            if (gnt[0]) begin
                prio_d = 1'b1;
            end else if (gnt[1]) begin
                prio_d = 1'b0;
            end

`ifdef MEMARB_LOCK_EN
            lock_act_d = 1'b0;
            lock_own_d = lock_own_q;
            lock_cnt_d = '0;
            // Continuing lock counts on; a fresh lock starts at one grant.
            cnt_next   = (lock_act_q && (lock_own_q == gnt[1])) ? lock_cnt_q + 1'b1 : CntW'(1);
            if ((|gnt) && port_lock[p][gnt[1]]) begin
                lock_own_d = gnt[1];
                // Reaching LOCK_MAX releases the lock; pointer already favours the other side.
                if (32'(cnt_next) < LOCK_MAX) begin
                    lock_act_d = 1'b1;
                    lock_cnt_d = cnt_next;
                end
            end
`endif
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                prio_q     <= 1'b0;
`ifdef MEMARB_LOCK_EN
                lock_act_q <= 1'b0;
                lock_own_q <= 1'b0;
                lock_cnt_q <= '0;
`endif
            end else begin
                prio_q     <= prio_d;
`ifdef MEMARB_LOCK_EN
                lock_act_q <= lock_act_d;
                lock_own_q <= lock_own_d;
                lock_cnt_q <= lock_cnt_d;
`endif
            end
        end

        assign port_gnt[p] = gnt;
    end

    // Read return tracking: pending flag plus owner of the read in flight.
    logic rd_pend_q, rd_pend_d;
    logic rd_own_q, rd_own_d;

    always_comb begin
        rd_pend_d = |port_gnt[1];
        rd_own_d  = port_gnt[1][1];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_pend_q <= 1'b0;
            rd_own_q  <= 1'b0;
        end else begin
            rd_pend_q <= rd_pend_d;
            rd_own_q  <= rd_own_d;
        end
    end

    always_comb begin
        bus.wgnt_0     = port_gnt[0][0];
        bus.wgnt_1     = port_gnt[0][1];
        bus.rgnt_0     = port_gnt[1][0];
        bus.rgnt_1     = port_gnt[1][1];
        bus.sram_we    = |port_gnt[0];
        bus.sram_re    = |port_gnt[1];
        bus.sram_waddr = '0;
        bus.sram_wdata = '0;
        bus.sram_raddr = '0;
        if (port_gnt[0][0]) begin
            bus.sram_waddr = bus.waddr_0;
            bus.sram_wdata = bus.wdata_0;
        end else if (port_gnt[0][1]) begin
            bus.sram_waddr = bus.waddr_1;
            bus.sram_wdata = bus.wdata_1;
        end
        if (port_gnt[1][0]) begin
            bus.sram_raddr = bus.raddr_0;
        end else if (port_gnt[1][1]) begin
            bus.sram_raddr = bus.raddr_1;
        end
        // Gated by rst_i so a read granted just before reset never surfaces.
        bus.rvalid_0 = !rst_i && rd_pend_q && !rd_own_q;
        bus.rvalid_1 = !rst_i && rd_pend_q && rd_own_q;
        bus.rdata_0  = bus.rvalid_0 ? bus.sram_rdata : '0;
        bus.rdata_1  = bus.rvalid_1 ? bus.sram_rdata : '0;
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed table, hand-written corner sequences and a
// randomized phase checked against a transaction-level model with a shadow memory.
module tb_mem_port_arbiter;
    localparam int unsigned AW = 10;
    localparam int unsigned DW = 64;
`ifdef MEMARB_LOCK_EN
    localparam int unsigned LOCK_MAX = 4;
`else
    localparam int unsigned LOCK_MAX = 16;
`endif

    logic clk_i = 1'b0;
    logic rst_i;
    always #5 clk_i = ~clk_i;

    mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    mem_port_arbiter #(.AW(AW), .DW(DW), .LOCK_MAX(LOCK_MAX)) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .bus  (bus)
    );

    // SRAM model: read-before-write, data valid one cycle after sram_re.
    logic [DW-1:0] mem [1 << AW];
    logic [DW-1:0] rdata_q;
    always @(posedge clk_i) begin
        if (bus.sram_we) mem[bus.sram_waddr] <= bus.sram_wdata;
        if (bus.sram_re) rdata_q <= mem[bus.sram_raddr];
    end
    assign bus.sram_rdata = rdata_q;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic adv();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        @(negedge clk_i);
    endtask

    task automatic set_idle();
        bus.wreq_0 = 0; bus.wlock_0 = 0; bus.waddr_0 = '0; bus.wdata_0 = '0;
        bus.wreq_1 = 0; bus.wlock_1 = 0; bus.waddr_1 = '0; bus.wdata_1 = '0;
        bus.rreq_0 = 0; bus.rlock_0 = 0; bus.raddr_0 = '0;
        bus.rreq_1 = 0; bus.rlock_1 = 0; bus.raddr_1 = '0;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        set_idle();
        adv();
        rst_i = 1'b0;
    endtask

    task automatic check_quiet(input string nm);
        check({nm, "_gnt"}, 64'({bus.wgnt_1, bus.wgnt_0, bus.rgnt_1, bus.rgnt_0}), 64'(0));
        check({nm, "_rvalid"}, 64'({bus.rvalid_1, bus.rvalid_0}), 64'(0));
        check({nm, "_we_re"}, 64'({bus.sram_we, bus.sram_re}), 64'(0));
        check({nm, "_waddr"}, 64'(bus.sram_waddr), 64'(0));
        check({nm, "_raddr"}, 64'(bus.sram_raddr), 64'(0));
        check({nm, "_wdata"}, bus.sram_wdata, 64'(0));
        check({nm, "_rdata0"}, bus.rdata_0, 64'(0));
        check({nm, "_rdata1"}, bus.rdata_1, 64'(0));
    endtask

    // Tie goes to the requester not served most recently (none served yet -> requester 0).
    function automatic int pick(input bit r0, input bit r1, input int last);
        if (r0 && r1) return (last == 0) ? 1 : 0;
        if (r0) return 0;
        if (r1) return 1;
        return -1;
    endfunction

    typedef struct {
        logic [1:0]    wreq;
        logic [1:0]    rreq;
        logic [1:0]    exp_wgnt;
        logic [1:0]    exp_rgnt;
        logic [AW-1:0] exp_waddr;
        logic [AW-1:0] exp_raddr;
    } vec_t;
    vec_t vecs [10];

    // Randomized-phase model state
    logic [DW-1:0] shadow [16];
    bit            known  [16];
    bit            wp [2];
    bit            rp [2];
    logic [AW-1:0] wa [2];
    logic [AW-1:0] ra [2];
    logic [DW-1:0] wd [2];
    int            w_last, r_last, wg, rg, rv_own;
    logic [DW-1:0] rv_data;
    bit            rv_known;
    logic [DW-1:0] exp_wdata;

    initial begin
        // Fixed addresses: waddr 0x010/0x020, raddr 0x005/0x006
        vecs[0] = '{2'b11, 2'b00, 2'b01, 2'b00, 10'h010, 10'h000};
        vecs[1] = '{2'b11, 2'b00, 2'b10, 2'b00, 10'h020, 10'h000};
        vecs[2] = '{2'b11, 2'b11, 2'b01, 2'b01, 10'h010, 10'h005};
        vecs[3] = '{2'b11, 2'b11, 2'b10, 2'b10, 10'h020, 10'h006};
        vecs[4] = '{2'b01, 2'b10, 2'b01, 2'b10, 10'h010, 10'h006};
        vecs[5] = '{2'b11, 2'b11, 2'b10, 2'b01, 10'h020, 10'h005};
        vecs[6] = '{2'b10, 2'b10, 2'b10, 2'b10, 10'h020, 10'h006};
        vecs[7] = '{2'b11, 2'b11, 2'b01, 2'b01, 10'h010, 10'h005};
        vecs[8] = '{2'b00, 2'b00, 2'b00, 2'b00, 10'h000, 10'h000};
        vecs[9] = '{2'b11, 2'b01, 2'b10, 2'b01, 10'h020, 10'h005};

        rst_i = 1'b1;
        set_idle();
        adv();
        adv();
        // Outputs stay quiet during reset even with every request raised
        bus.wreq_0 = 1; bus.wreq_1 = 1; bus.rreq_0 = 1; bus.rreq_1 = 1;
        settle();
        check_quiet("in_reset");
        adv();
        set_idle();
        rst_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            settle();
            check_quiet("idle");
            adv();
        end

        // Write port alternation with both requesting
        do_reset();
        bus.wreq_0 = 1; bus.waddr_0 = 10'h010; bus.wdata_0 = 64'h1111;
        bus.wreq_1 = 1; bus.waddr_1 = 10'h020; bus.wdata_1 = 64'h2222;
        for (int i = 0; i < 6; i++) begin
            settle();
            check("alt_wgnt", 64'({bus.wgnt_1, bus.wgnt_0}), (i % 2 == 0) ? 64'h1 : 64'h2);
            check("alt_waddr", 64'(bus.sram_waddr), (i % 2 == 0) ? 64'h010 : 64'h020);
            check("alt_we", 64'(bus.sram_we), 64'h1);
            adv();
        end

        // Directed table
        do_reset();
        bus.waddr_0 = 10'h010; bus.wdata_0 = 64'h1111;
        bus.waddr_1 = 10'h020; bus.wdata_1 = 64'h2222;
        bus.raddr_0 = 10'h005; bus.raddr_1 = 10'h006;
        for (int i = 0; i < 10; i++) begin
            bus.wreq_0 = vecs[i].wreq[0]; bus.wreq_1 = vecs[i].wreq[1];
            bus.rreq_0 = vecs[i].rreq[0]; bus.rreq_1 = vecs[i].rreq[1];
            exp_wdata = vecs[i].exp_wgnt[0] ? 64'h1111 : vecs[i].exp_wgnt[1] ? 64'h2222 : '0;
            settle();
            check($sformatf("tbl%0d_wgnt", i), 64'({bus.wgnt_1, bus.wgnt_0}),
                  64'(vecs[i].exp_wgnt));
            check($sformatf("tbl%0d_rgnt", i), 64'({bus.rgnt_1, bus.rgnt_0}),
                  64'(vecs[i].exp_rgnt));
            check($sformatf("tbl%0d_waddr", i), 64'(bus.sram_waddr), 64'(vecs[i].exp_waddr));
            check($sformatf("tbl%0d_raddr", i), 64'(bus.sram_raddr), 64'(vecs[i].exp_raddr));
            check($sformatf("tbl%0d_wdata", i), bus.sram_wdata, exp_wdata);
            check($sformatf("tbl%0d_we_re", i), 64'({bus.sram_we, bus.sram_re}),
                  64'({|vecs[i].exp_wgnt, |vecs[i].exp_rgnt}));
            adv();
        end

        // Back-to-back reads by alternating requesters
        do_reset();
        bus.wreq_0 = 1; bus.waddr_0 = 10'h005; bus.wdata_0 = 64'hA;
        adv();
        bus.waddr_0 = 10'h006; bus.wdata_0 = 64'hB;
        adv();
        set_idle();
        bus.rreq_0 = 1; bus.raddr_0 = 10'h005;
        settle();
        check("b2b_rgnt0", 64'(bus.rgnt_0), 64'h1);
        adv();
        bus.rreq_0 = 0; bus.rreq_1 = 1; bus.raddr_1 = 10'h006;
        settle();
        check("b2b_rgnt1", 64'(bus.rgnt_1), 64'h1);
        check("b2b_rvalid_t1", 64'({bus.rvalid_1, bus.rvalid_0}), 64'h1);
        check("b2b_rdata0_t1", bus.rdata_0, 64'hA);
        check("b2b_rdata1_t1", bus.rdata_1, 64'h0);
        adv();
        bus.rreq_1 = 0;
        settle();
        check("b2b_rvalid_t2", 64'({bus.rvalid_1, bus.rvalid_0}), 64'h2);
        check("b2b_rdata1_t2", bus.rdata_1, 64'hB);
        check("b2b_rdata0_t2", bus.rdata_0, 64'h0);
        adv();

        // Same-cycle read and write to one address returns the old word
        bus.wreq_0 = 1; bus.waddr_0 = 10'h007; bus.wdata_0 = 64'h0;
        adv();
        bus.wdata_0 = 64'h1234;
        bus.rreq_1 = 1; bus.raddr_1 = 10'h007;
        settle();
        check("raw_gnts", 64'({bus.wgnt_0, bus.rgnt_1}), 64'h3);
        adv();
        set_idle();
        settle();
        check("raw_old", bus.rdata_1, 64'h0);
        check("raw_old_valid", 64'(bus.rvalid_1), 64'h1);
        adv();
        bus.rreq_0 = 1; bus.raddr_0 = 10'h007;
        adv();
        bus.rreq_0 = 0;
        settle();
        check("raw_new", bus.rdata_0, 64'h1234);
        adv();

        // Reset right after a read grant: no late rvalid, pointers back to requester 0
        bus.rreq_1 = 1; bus.raddr_1 = 10'h005;
        bus.wreq_0 = 1; bus.waddr_0 = 10'h3F0;
        settle();
        check("rst_pre_gnt", 64'({bus.rgnt_1, bus.wgnt_0}), 64'h3);
        adv();
        set_idle();
        rst_i = 1'b1;
        settle();
        check("rst_rvalid_in", 64'({bus.rvalid_1, bus.rvalid_0}), 64'h0);
        adv();
        rst_i = 1'b0;
        bus.rreq_0 = 1; bus.rreq_1 = 1; bus.wreq_0 = 1; bus.wreq_1 = 1;
        settle();
        check("rst_rvalid_after", 64'({bus.rvalid_1, bus.rvalid_0}), 64'h0);
        check("rst_first_rgnt", 64'({bus.rgnt_1, bus.rgnt_0}), 64'h1);
        check("rst_first_wgnt", 64'({bus.wgnt_1, bus.wgnt_0}), 64'h1);
        adv();

`ifdef MEMARB_LOCK_EN
        // Locked read by requester 0 is cut after LOCK_MAX grants
        do_reset();
        bus.rreq_0 = 1; bus.rlock_0 = 1; bus.raddr_0 = 10'h005;
        bus.rreq_1 = 1; bus.raddr_1 = 10'h006;
        for (int i = 0; i < 6; i++) begin
            settle();
            check($sformatf("lock_c%0d", i), 64'({bus.rgnt_1, bus.rgnt_0}),
                  (i == 4) ? 64'h2 : 64'h1);
            adv();
        end
`endif

        // Randomized traffic against the transaction model
        do_reset();
        w_last = -1; r_last = -1; rv_own = -1; rv_known = 0; rv_data = '0;
        for (int k = 0; k < 2; k++) begin
            wp[k] = 0; rp[k] = 0; wa[k] = '0; ra[k] = '0; wd[k] = '0;
        end
        for (int a = 0; a < 16; a++) begin
            known[a] = 0; shadow[a] = '0;
        end
        for (int c = 0; c < 1500; c++) begin
            for (int k = 0; k < 2; k++) begin
                if (!wp[k] && ($urandom_range(1, 0) == 1)) begin
                    wp[k] = 1;
                    wa[k] = AW'($urandom_range(15, 0));
                    wd[k] = {$urandom, $urandom};
                end
                if (!rp[k] && ($urandom_range(1, 0) == 1)) begin
                    rp[k] = 1;
                    ra[k] = AW'($urandom_range(15, 0));
                end
            end
            bus.wreq_0 = wp[0]; bus.waddr_0 = wa[0]; bus.wdata_0 = wd[0];
            bus.wreq_1 = wp[1]; bus.waddr_1 = wa[1]; bus.wdata_1 = wd[1];
            bus.rreq_0 = rp[0]; bus.raddr_0 = ra[0];
            bus.rreq_1 = rp[1]; bus.raddr_1 = ra[1];
`ifdef MEMARB_LOCK_EN
            bus.wlock_0 = 0; bus.wlock_1 = 0; bus.rlock_0 = 0; bus.rlock_1 = 0;
`else
            bus.wlock_0 = ($urandom_range(1, 0) == 1); bus.wlock_1 = ($urandom_range(1, 0) == 1);
            bus.rlock_0 = ($urandom_range(1, 0) == 1); bus.rlock_1 = ($urandom_range(1, 0) == 1);
`endif
            wg = pick(wp[0], wp[1], w_last);
            rg = pick(rp[0], rp[1], r_last);
            settle();
            check("rnd_wgnt", 64'({bus.wgnt_1, bus.wgnt_0}), 64'({wg == 1, wg == 0}));
            check("rnd_rgnt", 64'({bus.rgnt_1, bus.rgnt_0}), 64'({rg == 1, rg == 0}));
            check("rnd_we_re", 64'({bus.sram_we, bus.sram_re}), 64'({wg >= 0, rg >= 0}));
            if (wg >= 0) begin
                check("rnd_waddr", 64'(bus.sram_waddr), 64'(wa[wg]));
                check("rnd_wdata", bus.sram_wdata, wd[wg]);
            end else begin
                check("rnd_waddr_idle", 64'(bus.sram_waddr), 64'(0));
            end
            if (rg >= 0) begin
                check("rnd_raddr", 64'(bus.sram_raddr), 64'(ra[rg]));
            end else begin
                check("rnd_raddr_idle", 64'(bus.sram_raddr), 64'(0));
            end
            check("rnd_rvalid", 64'({bus.rvalid_1, bus.rvalid_0}),
                  64'({rv_own == 1, rv_own == 0}));
            if (rv_own == 0 && rv_known) check("rnd_rdata0", bus.rdata_0, rv_data);
            if (rv_own != 0) check("rnd_rdata0_zero", bus.rdata_0, 64'(0));
            if (rv_own == 1 && rv_known) check("rnd_rdata1", bus.rdata_1, rv_data);
            if (rv_own != 1) check("rnd_rdata1_zero", bus.rdata_1, 64'(0));
            // Read sees memory before this cycle's write
            rv_own = rg;
            if (rg >= 0) begin
                rv_known = known[ra[rg][3:0]];
                rv_data  = shadow[ra[rg][3:0]];
                rp[rg]   = 0;
                r_last   = rg;
            end
            if (wg >= 0) begin
                shadow[wa[wg][3:0]] = wd[wg];
                known[wa[wg][3:0]]  = 1;
                wp[wg] = 0;
                w_last = wg;
            end
            adv();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
